display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_pkg.sv | 37 +++
 rtl/hex_to_7seg.sv | 11 +
 rtl/display_scan.sv | 115 +++++++++++
 tb/tb_display_scan.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 4-digit 7-segment scanner:
// digit states, active-low segment codes for 0-F and active-low digit enables.
package display_pkg;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digitState_e;

    // Segment order {g,f,e,d,c,b,a}, active-low; entry 0 is the least significant slice.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

endpackage

// File: rtl/hex_to_7seg.sv
// Purely combinational hex nibble to active-low 7-segment pattern.
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/display_scan.sv
// Four-digit multiplexed display scanner: prescaled digit slots, per-frame input
// snapshot so a frame never shows a mix of old and new register values.
//
// state | meaning
// DIG0  | show snapshot datRa,  an = 1110
// DIG1  | show snapshot addrRa, an = 1101
// DIG2  | show snapshot datRb,  an = 1011
// DIG3  | show snapshot addrRb, an = 0111; tick here takes a new snapshot
module display_scan
    import display_pkg::*;
#(
    parameter int BIT_ADDR = 3,
    parameter int BIT_DATO = 4,
    parameter int PRESCALE = 50000
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [BIT_ADDR-1:0] addrRa,
    input  logic [BIT_DATO-1:0] datRa,
    input  logic [BIT_ADDR-1:0] addrRb,
    input  logic [BIT_DATO-1:0] datRb,
    output logic [6:0]          sseg,
    output logic [3:0]          an,
    output logic                frame_tick
);

    if (BIT_ADDR > 4 || BIT_ADDR < 1) begin : gBadAddr
        $error("display_scan: BIT_ADDR must be 1..4");
    end
    if (BIT_DATO != 4) begin : gBadDato
        $error("display_scan: BIT_DATO must be 4");
    end
    if (PRESCALE < 2) begin : gBadPrescale
        $error("display_scan: PRESCALE must be at least 2");
    end

    localparam int CNT_W = $clog2(PRESCALE);

    logic [CNT_W-1:0]    preCnt;
    logic                tick;
    logic                capture;
    digitState_e         state;
    digitState_e         stateNext;
    logic [BIT_ADDR-1:0] snapAddrA;
    logic [BIT_ADDR-1:0] snapAddrB;
    logic [BIT_DATO-1:0] snapDatA;
    logic [BIT_DATO-1:0] snapDatB;
    logic [3:0]          digit;
    logic [3:0]          anSel;
    logic [3:0]          hexIn;

    assign tick    = (preCnt == CNT_W'(PRESCALE - 1));
    assign capture = tick && (state == DIG3);

    always_ff @(posedge clk) begin
        if (!rst) begin
            preCnt    <= '0;
            state     <= DIG0;
            snapAddrA <= '0;
            snapAddrB <= '0;
            snapDatA  <= '0;
            snapDatB  <= '0;
        end else begin
            preCnt <= tick ? '0 : preCnt + CNT_W'(1);
            state  <= stateNext;
            if (capture) begin
                snapAddrA <= addrRa;
                snapAddrB <= addrRb;
                snapDatA  <= datRa;
                snapDatB  <= datRb;
            end
        end
    end

    always_comb begin
        stateNext = state;
        digit     = 4'h0;
        anSel     = AN_DIG0;
        case (state)
            DIG0: begin
                digit = 4'(snapDatA);
                anSel = AN_DIG0;
                if (tick) stateNext = DIG1;
            end
            DIG1: begin
                digit = 4'(snapAddrA);
                anSel = AN_DIG1;
                if (tick) stateNext = DIG2;
            end
            DIG2: begin
                digit = 4'(snapDatB);
                anSel = AN_DIG2;
                if (tick) stateNext = DIG3;
            end
            DIG3: begin
                digit = 4'(snapAddrB);
                anSel = AN_DIG3;
                if (tick) stateNext = DIG0;
            end
            default: stateNext = DIG0;
        endcase
    end

    // Reset forces the idle display even before the first edge has cleared the state.
    assign an         = rst ? anSel : AN_DIG0;
    assign hexIn      = rst ? digit : 4'h0;
    assign frame_tick = capture && rst;

    hex_to_7seg uDecode (
        .hex (hexIn),
        .seg (sseg)
    );

endmodule

// File: tb/tb_display_scan.sv
// Randomized self-checking bench for display_scan with PRESCALE = 4, compared
// against a frame/slot arithmetic model of the scanner.
module tb_display_scan;

    localparam int BIT_ADDR = 3;
    localparam int BIT_DATO = 4;
    localparam int PRESCALE = 4;
    localparam int FRAME    = 4 * PRESCALE;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [BIT_ADDR-1:0] addrRa = '0;
    logic [BIT_DATO-1:0] datRa  = '0;
    logic [BIT_ADDR-1:0] addrRb = '0;
    logic [BIT_DATO-1:0] datRb  = '0;
    logic [6:0]          sseg;
    logic [3:0]          an;
    logic                frame_tick;

    int nChecks = 0;
    int nFails  = 0;

    // Model: k = cycles since the last reset edge; snapshot taken when k % FRAME == FRAME-1.
    int        k = 0;
    int        cyc = 0;
    logic [3:0] mDatA = '0, mDatB = '0, mAddrA = '0, mAddrB = '0;
    logic [6:0] segRef [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    display_scan #(
        .BIT_ADDR (BIT_ADDR),
        .BIT_DATO (BIT_DATO),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addrRa     (addrRa),
        .datRa      (datRa),
        .addrRb     (addrRb),
        .datRb      (datRb),
        .sseg       (sseg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic checkOutputs();
        int         slot;
        logic [3:0] d;
        logic [3:0] expAn;
        logic [6:0] expSeg;
        logic       expFt;
        if (!rst) begin
            expAn  = 4'b1110;
            expSeg = 7'b1000000;
            expFt  = 1'b0;
        end else begin
            slot = (k / PRESCALE) % 4;
            case (slot)
                0:       d = mDatA;
                1:       d = mAddrA;
                2:       d = mDatB;
                default: d = mAddrB;
            endcase
            expAn  = ~(4'b0001 << slot);
            expSeg = segRef[d];
            expFt  = ((k % FRAME) == FRAME - 1);
        end
        checkEq("an", 32'(an), 32'(expAn));
        checkEq("sseg", 32'(sseg), 32'(expSeg));
        checkEq("frame_tick", 32'(frame_tick), 32'(expFt));
        checkEq("an_onehot", 32'($countones(~an)), 32'd1);
    endtask

    task automatic modelEdge();
        if (!rst) begin
            k = 0;
            mDatA = '0; mDatB = '0; mAddrA = '0; mAddrB = '0;
        end else begin
            if ((k % FRAME) == FRAME - 1) begin
                mDatA  = datRa;
                mDatB  = datRb;
                mAddrA = 4'(addrRa);
                mAddrB = 4'(addrRb);
            end
            k++;
        end
    endtask

    task automatic runCycle();
        @(negedge clk);
        checkOutputs();
        @(posedge clk);
        modelEdge();
        cyc++;
        #1;
    endtask

    initial begin
        // Reset held for 3 cycles, then a fixed pattern scanned over two frames.
        rst = 1'b0;
        addrRa = 3'd5; datRa = 4'hA; addrRb = 3'd2; datRb = 4'h3;
        repeat (3) runCycle();
        rst = 1'b1;
        repeat (2 * FRAME) runCycle();

        // Mid-frame change of datRa must not show until the next snapshot.
        while ((k % FRAME) != FRAME / 2) runCycle();
        datRa = 4'h7;
        repeat (2 * FRAME) runCycle();

        // Decode sweep: each code presented for one full frame.
        for (int v = 0; v < 16; v++) begin
            datRa  = 4'(v);
            addrRa = 3'($urandom_range(0, 7));
            repeat (FRAME) runCycle();
        end

        // Random inputs every cycle with occasional mid-frame resets.
        for (int i = 0; i < 400; i++) begin
            addrRa = 3'($urandom); datRa = 4'($urandom);
            addrRb = 3'($urandom); datRb = 4'($urandom);
            rst = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            runCycle();
        end
        rst = 1'b1;

        // Reset landing on the DIG3 tick: reset wins, snapshots cleared.
        addrRa = 3'd7; datRa = 4'hE; addrRb = 3'd6; datRb = 4'h9;
        repeat (FRAME + 1) runCycle();
        for (int i = 0; i < 2 * FRAME && (k % FRAME) != FRAME - 1; i++) runCycle();
        checkEq("collision_reach", 32'(k % FRAME), 32'(FRAME - 1));
        rst = 1'b0;
        runCycle();
        rst = 1'b1;
        repeat (2 * FRAME) runCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
